// File: rtl/renas_package.sv
// rtl/renas_package.sv - shared types and constants for the renas write buffer
package renas_package;

  localparam int DATA_LENGTH = 32;
  localparam int BYTE_OFFSET = 2;
  localparam int PTR_LENGTH  = DATA_LENGTH - BYTE_OFFSET;
  localparam int WB_DEPTH    = 4;

  typedef struct packed {
    logic                   valid;
    logic [PTR_LENGTH-1:0]  ptr;
    logic [DATA_LENGTH-1:0] data;
  } wb_entry_type;

  typedef enum logic [1:0] {
    WB_IDLE    = 2'd0,
    WB_REQ     = 2'd1,
    WB_RELEASE = 2'd2
  } wb_state_type;

endpackage

// File: rtl/renas_mem_write_buffer_if.sv
// rtl/renas_mem_write_buffer_if.sv - cache push, memory drain and lookup signals of the write buffer
interface renas_mem_write_buffer_if;
  import renas_package::*;

  logic                              wb_req;
  logic [DATA_LENGTH+PTR_LENGTH-1:0] wb_data;
  logic                              wb_ack;
  logic                              full_flag;
  logic                              empty_flag;
  logic                              drain_hold;
  logic                              mem_req;
  logic [DATA_LENGTH-1:0]            mem_addr;
  logic [DATA_LENGTH-1:0]            mem_wdata;
  logic                              mem_ack;
  logic [PTR_LENGTH-1:0]             lkup_ptr;
  logic                              lkup_hit;
  logic [DATA_LENGTH-1:0]            lkup_data;

  modport slave (
    input  wb_req, wb_data, drain_hold, mem_ack, lkup_ptr,
    output wb_ack, full_flag, empty_flag, mem_req, mem_addr, mem_wdata, lkup_hit, lkup_data
  );

  modport master (
    output wb_req, wb_data, drain_hold, mem_ack, lkup_ptr,
    input  wb_ack, full_flag, empty_flag, mem_req, mem_addr, mem_wdata, lkup_hit, lkup_data
  );

endinterface

// File: rtl/renas_wb_lookup.sv
// rtl/renas_wb_lookup.sv - newest-first match search over the write buffer entries
module renas_wb_lookup
  import renas_package::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  wb_entry_type           entries_i [DEPTH],
  input  logic [IDX_W-1:0]       wr_ptr_i,
  input  logic [DEPTH-1:0]       skip_i,
  input  logic [PTR_LENGTH-1:0]  ptr_i,
  output logic                   hit_o,
  output logic [IDX_W-1:0]       idx_o
);

  logic [IDX_W-1:0] slot;

  // Walk oldest to newest so the newest match is the last one written.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    slot  = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      slot = wr_ptr_i - IDX_W'(k);
      if (entries_i[slot].valid && !skip_i[slot] && (entries_i[slot].ptr == ptr_i)) begin
        hit_o = 1'b1;
        idx_o = slot;
      end
    end
  end

endmodule

// File: rtl/renas_mem_write_buffer.sv
// rtl/renas_mem_write_buffer.sv - posted-write FIFO from D-cache write-back to memory data port
// Optional in-place write merging is enabled by defining RENAS_WB_MERGE_EN.
module renas_mem_write_buffer
  import renas_package::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input logic                        clk_l2,
  input logic                        rst_n,
  renas_mem_write_buffer_if.slave    bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

  wb_entry_type           entries_q [DEPTH];
  logic [IDX_W-1:0]       rd_ptr_q;
  logic [IDX_W-1:0]       wr_ptr_q;
  logic [IDX_W:0]         count_q;
  logic [IDX_W:0]         count_d;
  wb_state_type           state_q;
  logic                   wb_ack_q;
  logic                   mem_req_q;
  logic [DATA_LENGTH-1:0] mem_addr_q;
  logic [DATA_LENGTH-1:0] mem_wdata_q;

  logic [PTR_LENGTH-1:0]  push_ptr;
  logic [DATA_LENGTH-1:0] push_data;
  logic                   full;
  logic                   empty;
  logic                   pop;
  logic                   push_alloc;
  logic                   push_merge;
  logic [IDX_W-1:0]       merge_idx;
  logic                   lkup_hit;
  logic [IDX_W-1:0]       lkup_idx;

  assign push_ptr  = bus.wb_data[PTR_LENGTH-1:0];
  assign push_data = bus.wb_data[PTR_LENGTH +: DATA_LENGTH];
  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign pop       = (state_q == WB_REQ) && bus.mem_ack;

  renas_wb_lookup #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_lkup (
    .entries_i (entries_q),
    .wr_ptr_i  (wr_ptr_q),
    .skip_i    ({DEPTH{1'b0}}),
    .ptr_i     (bus.lkup_ptr),
    .hit_o     (lkup_hit),
    .idx_o     (lkup_idx)
  );

`ifdef RENAS_WB_MERGE_EN
  logic [DEPTH-1:0] merge_skip;
  logic             merge_hit;

  // The head is off-limits once its write has been launched.
  always_comb begin
    merge_skip = '0;
    if (state_q != WB_IDLE) merge_skip[rd_ptr_q] = 1'b1;
  end

  renas_wb_lookup #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_merge (
    .entries_i (entries_q),
    .wr_ptr_i  (wr_ptr_q),
    .skip_i    (merge_skip),
    .ptr_i     (push_ptr),
    .hit_o     (merge_hit),
    .idx_o     (merge_idx)
  );

  assign push_merge = bus.wb_req && merge_hit;
  assign push_alloc = bus.wb_req && !merge_hit && !full;
`else
  assign merge_idx  = '0;
  assign push_merge = 1'b0;
  assign push_alloc = bus.wb_req && !full;
`endif

  always_comb begin
    count_d = count_q;
    if (push_alloc && !pop)      count_d = count_q + 1'b1;
    else if (!push_alloc && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_l2 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= WB_IDLE;
      wb_ack_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      wb_ack_q <= push_alloc | push_merge;
      count_q  <= count_d;
      if (push_alloc) begin
        entries_q[wr_ptr_q] <= '{valid: 1'b1, ptr: push_ptr, data: push_data};
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end
      if (push_merge) entries_q[merge_idx].data <= push_data;
      if (pop) begin
        entries_q[rd_ptr_q].valid <= 1'b0;
        rd_ptr_q                  <= rd_ptr_q + 1'b1;
      end
      case (state_q)
        WB_IDLE: begin
          if (!empty && !bus.drain_hold) begin
            state_q     <= WB_REQ;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= {entries_q[rd_ptr_q].ptr, {BYTE_OFFSET{1'b0}}};
            mem_wdata_q <= entries_q[rd_ptr_q].data;
          end
        end
        WB_REQ: begin
          if (bus.mem_ack) begin
            state_q   <= WB_RELEASE;
            mem_req_q <= 1'b0;
          end
        end
        WB_RELEASE: begin
          // Holding here until ack falls keeps one write per req/ack pair.
          if (!bus.mem_ack) state_q <= WB_IDLE;
        end
        default: begin
          state_q   <= WB_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wb_ack     = wb_ack_q;
  assign bus.full_flag  = full;
  assign bus.empty_flag = empty;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.lkup_hit   = lkup_hit;
  assign bus.lkup_data  = lkup_hit ? entries_q[lkup_idx].data : '0;

endmodule

// File: tb/tb_renas_mem_write_buffer.sv
// tb/tb_renas_mem_write_buffer.sv - self-checking bench for renas_mem_write_buffer
module tb_renas_mem_write_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  renas_mem_write_buffer_if bus();

  renas_mem_write_buffer dut (
    .clk_l2 (clk),
    .rst_n  (rst_n),
    .bus    (bus.slave)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;
  bit auto_ack = 1'b0;
  int ack_len  = 1;
  int hold_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: pending writes in push order, plus the drain phase.
  typedef struct { logic [29:0] ptr; logic [31:0] data; } wr_t;
  wr_t  mq[$];
  bit   m_req, m_rel, m_ack;
  logic [31:0] m_addr, m_wdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_req = 0; m_rel = 0; m_ack = 0; m_addr = '0; m_wdata = '0;
    end else begin
      automatic int  old_size = mq.size();
      automatic bit  merged = 0;
      automatic bit  accepted = 0;
      if (bus.wb_req) begin
`ifdef RENAS_WB_MERGE_EN
        for (int i = mq.size() - 1; i >= 0 && !merged; i--) begin
          if (mq[i].ptr == bus.wb_data[29:0] && !(i == 0 && (m_req || m_rel))) begin
            mq[i].data = bus.wb_data[61:30];
            merged = 1;
          end
        end
`endif
        accepted = merged || (old_size < 4);
      end
      if (m_req) begin
        if (bus.mem_ack) begin
          void'(mq.pop_front());
          m_req = 0;
          m_rel = 1;
        end
      end else if (m_rel) begin
        if (!bus.mem_ack) m_rel = 0;
      end else if (old_size > 0 && !bus.drain_hold) begin
        m_req   = 1;
        m_addr  = {mq[0].ptr, 2'b00};
        m_wdata = mq[0].data;
      end
      if (accepted && !merged) mq.push_back('{ptr: bus.wb_data[29:0], data: bus.wb_data[61:30]});
      m_ack = accepted;
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      automatic bit          e_hit = 0;
      automatic logic [31:0] e_data = '0;
      for (int i = 0; i < mq.size() && !e_hit; i++) begin
        if (mq[mq.size() - 1 - i].ptr == bus.lkup_ptr) begin
          e_hit  = 1;
          e_data = mq[mq.size() - 1 - i].data;
        end
      end
      chk("m_wb_ack", bus.wb_ack, m_ack);
      chk("m_full", bus.full_flag, mq.size() == 4);
      chk("m_empty", bus.empty_flag, mq.size() == 0);
      chk("m_mem_req", bus.mem_req, m_req);
      if (m_req) begin
        chk("m_mem_addr", bus.mem_addr, m_addr);
        chk("m_mem_wdata", bus.mem_wdata, m_wdata);
      end
      chk("m_lkup_hit", bus.lkup_hit, e_hit);
      chk("m_lkup_data", bus.lkup_data, e_data);
    end
  end

  // Memory responder: ack one cycle after req, held for ack_len cycles.
  always begin
    @(posedge clk); #1;
    if (!rst_n || !auto_ack) begin
      if (!auto_ack) bus.mem_ack = 1'b0;
    end else if (bus.mem_req && !bus.mem_ack) begin
      bus.mem_ack = 1'b1;
      hold_cnt = ack_len;
    end else if (bus.mem_ack) begin
      if (hold_cnt > 1) hold_cnt--;
      else bus.mem_ack = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic push(input logic [29:0] p, input logic [31:0] d);
    bit got = 0;
    bus.wb_data = {d, p};
    bus.wb_req  = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (bus.wb_ack) got = 1;
    end
    bus.wb_req = 1'b0;
    chk("push_ack", got, 1'b1);
  endtask

  task automatic wait_req();
    bit got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      if (bus.mem_req) got = 1;
      else tick();
    end
    chk("wait_mem_req", got, 1'b1);
  endtask

  task automatic wait_idle();
    bit got = 0;
    for (int i = 0; i < 80 && !got; i++) begin
      tick();
      if (bus.empty_flag && !bus.mem_req && !bus.mem_ack) got = 1;
    end
    tick(); tick();
    chk("wait_idle", got, 1'b1);
  endtask

  logic [31:0] exp_addrs [5];
  logic [31:0] seen_addrs [5];

  initial begin
    bus.wb_req = 0; bus.wb_data = '0; bus.drain_hold = 0;
    bus.mem_ack = 0; bus.lkup_ptr = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_empty", bus.empty_flag, 1'b1);
    chk("rst_full", bus.full_flag, 1'b0);
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_wb_ack", bus.wb_ack, 1'b0);
    chk_en = 1'b1;

    // Single write with one-cycle ack
    auto_ack = 1; ack_len = 1;
    push(30'h100, 32'hDEADBEEF);
    chk("t1_req_before", bus.mem_req, 1'b0);
    tick();
    chk("t1_req_latency", bus.mem_req, 1'b1);
    chk("t1_addr", bus.mem_addr, 32'h400);
    chk("t1_wdata", bus.mem_wdata, 32'hDEADBEEF);
    wait_idle();
    chk("t1_empty", bus.empty_flag, 1'b1);

    // Fill under hold, fifth push blocked, then ordered drain
    bus.drain_hold = 1;
    for (int i = 0; i < 4; i++) push(30'h10 + 30'(i), 32'hA0 + 32'(i));
    chk("t2_full", bus.full_flag, 1'b1);
    bus.wb_data = {32'hA4, 30'h14};
    bus.wb_req  = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_no_ack_full", bus.wb_ack, 1'b0);
    end
    bus.drain_hold = 0;
    for (int i = 0; i < 5; i++) begin
      exp_addrs[i]  = 32'h40 + 32'(4 * i);
      seen_addrs[i] = '0;
    end
    begin
      automatic int  nw = 0, fall_cyc = -1, ack_cyc = -1;
      automatic bit  prev_req = 0;
      for (int i = 0; i < 80 && !(nw == 5 && bus.empty_flag && !bus.mem_req); i++) begin
        tick();
        if (bus.mem_req && !prev_req && nw < 5) begin
          seen_addrs[nw] = bus.mem_addr;
          nw++;
        end
        if (!bus.mem_req && prev_req && fall_cyc < 0) fall_cyc = cyc;
        if (bus.wb_ack && bus.wb_req) begin
          ack_cyc = cyc;
          bus.wb_req = 0;
        end
        prev_req = bus.mem_req;
      end
      chk("t2_writes", nw, 5);
      for (int i = 0; i < 5; i++) chk("t2_order", seen_addrs[i], exp_addrs[i]);
      chk("t2_ack_after_pop", ack_cyc, fall_cyc + 1);
    end
    bus.wb_req = 0;
    wait_idle();

    // Lookup: newest of two matching entries wins
    bus.drain_hold = 1;
    push(30'h20, 32'h1);
    push(30'h20, 32'h2);
    bus.lkup_ptr = 30'h20;
    tick();
    chk("t3_hit", bus.lkup_hit, 1'b1);
    chk("t3_data", bus.lkup_data, 32'h2);
    bus.lkup_ptr = 30'h21;
    tick();
    chk("t3_miss", bus.lkup_hit, 1'b0);
    chk("t3_miss_data", bus.lkup_data, 32'h0);
    bus.lkup_ptr = 30'h20;
    bus.drain_hold = 0;
    wait_idle();
    bus.lkup_ptr = '0;

    // Stretched ack pops only once
    bus.drain_hold = 1; ack_len = 3;
    push(30'h30, 32'h33);
    push(30'h31, 32'h44);
    bus.drain_hold = 0;
    wait_req();
    begin
      automatic bit fell = 0;
      for (int i = 0; i < 10 && !fell; i++) begin
        tick();
        if (!bus.mem_req) fell = 1;
      end
      chk("t4_req_fell", fell, 1'b1);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t4_ack_high", bus.mem_ack, 1'b1);
      chk("t4_no_rereq", bus.mem_req, 1'b0);
      chk("t4_one_left", bus.empty_flag, 1'b0);
    end
    wait_idle();
    ack_len = 1;

    // Reset while a request is outstanding
    auto_ack = 0;
    push(30'h40, 32'h77);
    wait_req();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_req_drop", bus.mem_req, 1'b0);
    chk("t5_empty", bus.empty_flag, 1'b1);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_no_req", bus.mem_req, 1'b0);
    end
    auto_ack = 1;

`ifdef RENAS_WB_MERGE_EN
    // Merge into a full buffer, then check the drained data
    bus.drain_hold = 1;
    for (int i = 0; i < 4; i++) push(30'h60 + 30'(i), 32'hB0 + 32'(i));
    push(30'h62, 32'h55);
    chk("t6_still_full", bus.full_flag, 1'b1);
    bus.drain_hold = 0;
    begin
      automatic bit          seen = 0;
      automatic logic [31:0] got_data = '0;
      automatic bit          prev_req = 0;
      for (int i = 0; i < 60; i++) begin
        tick();
        if (bus.mem_req && !prev_req && bus.mem_addr == 32'h188) begin
          seen = 1;
          got_data = bus.mem_wdata;
        end
        prev_req = bus.mem_req;
      end
      chk("t6_merge_seen", seen, 1'b1);
      chk("t6_merge_data", got_data, 32'h55);
    end
    wait_idle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
